// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the shared 256-bit memory port: one outstanding
// transaction at a time, ack and read line routed back to the owning requester.
module mem_arbiter #(
  parameter int unsigned DATA_PRIO = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_enable_i,
  input  logic         i_write_i,
  input  logic [31:0]  i_addr_i,
  input  logic [255:0] i_data_i,
  output logic         i_ack_o,
  input  logic         d_enable_i,
  input  logic         d_write_i,
  input  logic [31:0]  d_addr_i,
  input  logic [255:0] d_data_i,
  output logic         d_ack_o,
  output logic [255:0] rdata_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic         busy_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic           owner_q, owner_d;            // 1 = D owns the transaction
  logic           last_grant_q, last_grant_d;  // 1 = D was granted last
  logic           mem_enable_q, mem_enable_d;
  logic           mem_write_q, mem_write_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [255:0]   mem_data_q, mem_data_d;
  logic [255:0]   rdata_q, rdata_d;
  logic           i_ack_q, i_ack_d;
  logic           d_ack_q, d_ack_d;
  logic           busy_q, busy_d;
  logic           pick_d;

  // Line addressing drops the byte offset.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr_i[4:0], d_addr_i[4:0]};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    rdata_d      = rdata_q;
    busy_d       = busy_q;
    i_ack_d      = 1'b0;
    d_ack_d      = 1'b0;
    pick_d       = d_enable_i && (!i_enable_i || (DATA_PRIO != 0) || !last_grant_q);

    case (state_q)
      IDLE: begin
        if (i_enable_i || d_enable_i) begin
          owner_d      = pick_d;
          last_grant_d = pick_d;
          mem_write_d  = pick_d ? d_write_i : i_write_i;
          mem_addr_d   = pick_d ? {d_addr_i[31:5], 5'b0} : {i_addr_i[31:5], 5'b0};
          mem_data_d   = pick_d ? d_data_i : i_data_i;
          mem_enable_d = 1'b1;
          busy_d       = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          rdata_d      = mem_data_i;
          mem_enable_d = 1'b0;
          mem_write_d  = 1'b0;
          i_ack_d      = !owner_q;
          d_ack_d      = owner_q;
          state_d      = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      rdata_q      <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      rdata_q      <= rdata_d;
      i_ack_q      <= i_ack_d;
      d_ack_q      <= d_ack_d;
      busy_q       <= busy_d;
    end
  end

  assign i_ack_o      = i_ack_q;
  assign d_ack_o      = d_ack_q;
  assign rdata_o      = rdata_q;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand sequences for ties, sticky
// enable and reset, then random traffic against a transaction-level model.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         i_enable_i, i_write_i, d_enable_i, d_write_i, mem_ack_i;
  logic [31:0]  i_addr_i, d_addr_i;
  logic [255:0] i_data_i, d_data_i, mem_data_i;

  logic         iack0, dack0, men0, mwr0, busy0, iack1, dack1, men1, mwr1, busy1;
  logic [31:0]  maddr0, maddr1;
  logic [255:0] mdata0, mdata1, rdata0, rdata1;

  logic         obs_iack, obs_dack, obs_men, obs_mwr, obs_busy;
  logic [31:0]  obs_maddr;
  logic [255:0] obs_mdata, obs_rdata;

  bit sel = 1'b0;
  int cyc = 0;
  int errors = 0;
  int checks = 0;

  localparam logic [255:0] AA    = {32{8'hAA}};
  localparam logic [255:0] P1234 = {16{16'h1234}};
  localparam logic [255:0] WI0   = {8{32'hC0DE_0001}};
  localparam logic [255:0] WI1   = {8{32'h0BAD_F00D}};
  localparam logic [255:0] WI2   = {8{32'h7777_0002}};
  localparam logic [255:0] WD1   = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] WD2   = {8{32'h1357_9BDF}};
  localparam logic [255:0] RD1   = {8{32'h0F0F_1234}};
  localparam logic [255:0] RD2   = {8{32'h8421_5A5A}};

  mem_arbiter #(.DATA_PRIO(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i),
    .i_enable_i(i_enable_i), .i_write_i(i_write_i), .i_addr_i(i_addr_i),
    .i_data_i(i_data_i), .i_ack_o(iack0),
    .d_enable_i(d_enable_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
    .d_data_i(d_data_i), .d_ack_o(dack0),
    .rdata_o(rdata0), .mem_enable_o(men0), .mem_write_o(mwr0), .mem_addr_o(maddr0),
    .mem_data_o(mdata0), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .busy_o(busy0)
  );

  mem_arbiter #(.DATA_PRIO(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i),
    .i_enable_i(i_enable_i), .i_write_i(i_write_i), .i_addr_i(i_addr_i),
    .i_data_i(i_data_i), .i_ack_o(iack1),
    .d_enable_i(d_enable_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
    .d_data_i(d_data_i), .d_ack_o(dack1),
    .rdata_o(rdata1), .mem_enable_o(men1), .mem_write_o(mwr1), .mem_addr_o(maddr1),
    .mem_data_o(mdata1), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .busy_o(busy1)
  );

  assign obs_iack  = sel ? iack1  : iack0;
  assign obs_dack  = sel ? dack1  : dack0;
  assign obs_men   = sel ? men1   : men0;
  assign obs_mwr   = sel ? mwr1   : mwr0;
  assign obs_busy  = sel ? busy1  : busy0;
  assign obs_maddr = sel ? maddr1 : maddr0;
  assign obs_mdata = sel ? mdata1 : mdata0;
  assign obs_rdata = sel ? rdata1 : rdata0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit           set_i;
    bit           set_d;
    bit           i_wr;
    bit           d_wr;
    logic [31:0]  i_addr;
    logic [31:0]  d_addr;
    logic [255:0] i_wd;
    logic [255:0] d_wd;
    bit           exp_d;
    logic [31:0]  exp_addr;
    bit           exp_wr;
    logic [255:0] exp_wd;
    int           lat;
    logic [255:0] rd;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] r256();
    logic [255:0] r;
    for (int unsigned k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_idle_inputs();
    i_enable_i = 1'b0; i_write_i = 1'b0; i_addr_i = '0; i_data_i = '0;
    d_enable_i = 1'b0; d_write_i = 1'b0; d_addr_i = '0; d_data_i = '0;
    mem_ack_i  = 1'b0; mem_data_i = '0;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    drive_idle_inputs();
    step();
    step();
    rst_i = 1'b0;
  endtask

  // One full transaction: grant on the next edge, hold for lat cycles, memory
  // ack, one-cycle owner ack, back to idle.
  task automatic serve(input bit exp_d, input logic [31:0] exp_addr, input bit exp_wr,
                       input logic [255:0] exp_wd, input int lat, input logic [255:0] rd,
                       input bit keep, output int gcyc);
    int w;
    mem_ack_i = 1'b0;
    step();
    w = 1;
    while (!obs_men && w < 20) begin
      step();
      w++;
    end
    gcyc = cyc;
    chk("grant_latency", 256'(w), 256'(1));
    chk("grant_addr", 256'(obs_maddr), 256'(exp_addr));
    chk("grant_write", 256'(obs_mwr), 256'(exp_wr));
    chk("grant_data", obs_mdata, exp_wd);
    chk("grant_busy", 256'(obs_busy), 256'(1));
    chk("grant_no_ack", 256'({obs_iack, obs_dack}), 256'(0));
    for (int k = 0; k < lat; k++) begin
      step();
      chk("hold_enable", 256'(obs_men), 256'(1));
      chk("hold_addr", 256'(obs_maddr), 256'(exp_addr));
      chk("hold_write", 256'(obs_mwr), 256'(exp_wr));
      chk("hold_data", obs_mdata, exp_wd);
    end
    mem_ack_i  = 1'b1;
    mem_data_i = rd;
    step();
    mem_ack_i  = 1'b0;
    chk("owner_i_ack", 256'(obs_iack), 256'(!exp_d));
    chk("owner_d_ack", 256'(obs_dack), 256'(exp_d));
    chk("ack_rdata", obs_rdata, rd);
    chk("ack_enable_low", 256'(obs_men), 256'(0));
    chk("ack_write_low", 256'(obs_mwr), 256'(0));
    chk("done_busy", 256'(obs_busy), 256'(1));
    if (!keep) begin
      if (exp_d) d_enable_i = 1'b0;
      else       i_enable_i = 1'b0;
    end
    step();
    chk("pulse_end", 256'({obs_iack, obs_dack}), 256'(0));
    chk("idle_busy", 256'(obs_busy), 256'(0));
    chk("idle_enable", 256'(obs_men), 256'(0));
    chk("rdata_held", obs_rdata, rd);
  endtask

  task automatic run_random(input bit prio, input int ncyc);
    int phase = 0;
    int lat = 0;
    bit last_d = 1'b1, owner_d = 1'b0, win_d;
    bit ip = 1'b0, dp = 1'b0, iwr = 1'b0, dwr = 1'b0, mack, e_wr = 1'b0, e_ia, e_da;
    logic [31:0]  ia = '0, da = '0, wa, e_addr = '0;
    logic [255:0] iw = '0, dw = '0, mdat, e_data = '0, e_rd = '0;
    sel = prio;
    apply_reset();
    for (int n = 0; n < ncyc; n++) begin
      if (!ip && $urandom_range(0, 3) == 0) begin
        ip = 1'b1; iwr = ($urandom_range(0, 1) == 1); ia = $urandom; iw = r256();
      end
      if (!dp && $urandom_range(0, 3) == 0) begin
        dp = 1'b1; dwr = ($urandom_range(0, 1) == 1); da = $urandom; dw = r256();
      end
      i_enable_i = ip; i_write_i = iwr; i_addr_i = ia; i_data_i = iw;
      d_enable_i = dp; d_write_i = dwr; d_addr_i = da; d_data_i = dw;
      mack = 1'b0;
      if (phase == 1) begin
        if (lat == 0) mack = 1'b1;
        else lat--;
      end else begin
        mack = ($urandom_range(0, 7) == 0);
      end
      mdat = r256();
      mem_ack_i  = mack;
      mem_data_i = mdat;
      step();
      e_ia = 1'b0;
      e_da = 1'b0;
      case (phase)
        0: if (ip || dp) begin
          win_d   = dp && (!ip || prio || !last_d);
          last_d  = win_d;
          owner_d = win_d;
          wa      = win_d ? da : ia;
          e_addr  = {wa[31:5], 5'b0};
          e_wr    = win_d ? dwr : iwr;
          e_data  = win_d ? dw : iw;
          lat     = $urandom_range(0, 6);
          phase   = 1;
        end
        1: if (mack) begin
          e_rd  = mdat;
          e_wr  = 1'b0;
          phase = 2;
          if (owner_d) begin
            e_da = 1'b1;
            if ($urandom_range(0, 3) != 0) dp = 1'b0;
          end else begin
            e_ia = 1'b1;
            if ($urandom_range(0, 3) != 0) ip = 1'b0;
          end
        end
        default: phase = 0;
      endcase
      chk("rnd_enable", 256'(obs_men), 256'(phase == 1));
      chk("rnd_busy", 256'(obs_busy), 256'(phase != 0));
      chk("rnd_i_ack", 256'(obs_iack), 256'(e_ia));
      chk("rnd_d_ack", 256'(obs_dack), 256'(e_da));
      chk("rnd_addr", 256'(obs_maddr), 256'(e_addr));
      chk("rnd_write", 256'(obs_mwr), 256'(e_wr));
      chk("rnd_data", obs_mdata, e_data);
      chk("rnd_rdata", obs_rdata, e_rd);
    end
  endtask

  initial begin
    int g1, g2, w;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0124, '0, WI0, '0,
                1'b0, 32'h0000_0120, 1'b0, WI0, 10, AA};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, '0, 32'h0000_0040, '0, P1234,
                1'b1, 32'h0000_0040, 1'b1, P1234, 4, {32{8'h55}}};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h1000_0007, 32'h2000_003F, WI1, WD1,
                1'b0, 32'h1000_0000, 1'b0, WI1, 0, RD1};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0,
                1'b1, 32'h2000_0020, 1'b0, WD1, 2, RD2};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, '0, WI2, '0,
                1'b0, 32'hFFFF_FFE0, 1'b1, WI2, 1, RD1};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_001F, 32'h3000_0100, WI0, WD2,
                1'b1, 32'h3000_0100, 1'b0, WD2, 3, RD2};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0,
                1'b0, 32'h0000_0000, 1'b1, WI0, 0, AA};

    // Reset state
    sel   = 1'b0;
    rst_i = 1'b1;
    drive_idle_inputs();
    step();
    step();
    chk("rst_enable", 256'(obs_men), 256'(0));
    chk("rst_write", 256'(obs_mwr), 256'(0));
    chk("rst_busy", 256'(obs_busy), 256'(0));
    chk("rst_acks", 256'({obs_iack, obs_dack}), 256'(0));
    chk("rst_addr", 256'(obs_maddr), 256'(0));
    chk("rst_data", obs_mdata, 256'(0));
    chk("rst_rdata", obs_rdata, 256'(0));
    rst_i = 1'b0;

    // Directed vectors, round-robin instance; last grant evolves row to row
    for (int r = 0; r < 7; r++) begin
      if (vecs[r].set_i) begin
        i_enable_i = 1'b1; i_write_i = vecs[r].i_wr;
        i_addr_i = vecs[r].i_addr; i_data_i = vecs[r].i_wd;
      end
      if (vecs[r].set_d) begin
        d_enable_i = 1'b1; d_write_i = vecs[r].d_wr;
        d_addr_i = vecs[r].d_addr; d_data_i = vecs[r].d_wd;
      end
      serve(vecs[r].exp_d, vecs[r].exp_addr, vecs[r].exp_wr, vecs[r].exp_wd,
            vecs[r].lat, vecs[r].rd, 1'b0, g1);
    end

    // Fixed data priority: D first on every tie, I served in between
    sel = 1'b1;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      i_enable_i = 1'b1; i_write_i = 1'b0; i_addr_i = 32'h0000_1000 + 32'(k * 64);
      i_data_i = WI1;
      d_enable_i = 1'b1; d_write_i = 1'b1; d_addr_i = 32'h0000_8000 + 32'(k * 64);
      d_data_i = WD2;
      serve(1'b1, 32'h0000_8000 + 32'(k * 64), 1'b1, WD2, k, RD1, 1'b0, g1);
      serve(1'b0, 32'h0000_1000 + 32'(k * 64), 1'b0, WI1, 1, RD2, 1'b0, g2);
    end

    // Sticky enable: same request held through DONE is granted again 3 cycles later
    sel = 1'b0;
    apply_reset();
    i_enable_i = 1'b1; i_write_i = 1'b0; i_addr_i = 32'h0000_0A04; i_data_i = WI2;
    serve(1'b0, 32'h0000_0A00, 1'b0, WI2, 0, RD1, 1'b1, g1);
    serve(1'b0, 32'h0000_0A00, 1'b0, WI2, 0, RD2, 1'b0, g2);
    chk("grant_spacing", 256'(g2 - g1), 256'(3));

    // Reset while waiting for memory, then a late memory ack
    apply_reset();
    d_enable_i = 1'b1; d_write_i = 1'b1; d_addr_i = 32'h0000_0080; d_data_i = WD1;
    step();
    w = 1;
    while (!obs_men && w < 20) begin
      step();
      w++;
    end
    chk("mid_grant", 256'(obs_men), 256'(1));
    step();
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_enable", 256'(obs_men), 256'(0));
    chk("async_busy", 256'(obs_busy), 256'(0));
    chk("async_acks", 256'({obs_iack, obs_dack}), 256'(0));
    d_enable_i = 1'b0;
    mem_ack_i  = 1'b1;
    mem_data_i = RD1;
    step();
    rst_i = 1'b0;
    step();
    chk("late_ack_none", 256'({obs_iack, obs_dack}), 256'(0));
    chk("late_ack_idle", 256'({obs_men, obs_busy}), 256'(0));
    mem_ack_i = 1'b0;
    step();
    chk("late_ack_after", 256'({obs_iack, obs_dack, obs_busy}), 256'(0));

    // Random traffic on both arbitration policies
    run_random(1'b0, 1500);
    run_random(1'b1, 1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single 256-bit off-chip data-memory port between the instruction-cache refill path (requester I) and `dcache_top` (requester D). It sits between the two cache controllers and the memory model. Each requester sees a private request/ack handshake; the arbiter serializes them into one outstanding memory transaction at a time and routes the ack and read data back to the owner.

## Interface
- `DATA_PRIO`, default 0: 0 selects round-robin arbitration; 1 gives D fixed priority over I.
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `i_enable_i` input 1: I request valid; held with stable fields until `i_ack_o`.
- `i_write_i` input 1: I request is a write (1) or read (0).
- `i_addr_i` input 32: I byte address.
- `i_data_i` input 256: I write line.
- `i_ack_o` output 1: one-cycle completion pulse to I.
- `d_enable_i`, `d_write_i`, `d_addr_i` (32), `d_data_i` (256): inputs, same meaning for D.
- `d_ack_o` output 1: one-cycle completion pulse to D.
- `rdata_o` output 256: read line returned to the acked requester.
- `mem_enable_o` output 1: memory request.
- `mem_write_o` output 1: memory write.
- `mem_addr_o` output 32: memory line address.
- `mem_data_o` output 256: memory write line.
- `mem_data_i` input 256: memory read line.
- `mem_ack_i` input 1: memory completion.
- `busy_o` output 1: a transaction is in flight.

## Operation
- States: IDLE, BUSY, DONE. The state and every output are registered.
- IDLE:
  - If neither enable is high, remain in IDLE.
  - Otherwise pick a winner:
    - If only one requester is enabled, it wins.
    - If both are enabled and `DATA_PRIO`=1, D wins.
    - If both are enabled and `DATA_PRIO`=0, the requester not in `last_grant` wins.
  - On a win:
    - Latch the winner's write, address and data into `mem_*` registers.
    - `mem_addr_o` = {addr[31:5], 5'b0}.
    - Set `owner`, set `last_grant` = winner, set `mem_enable_o`=1 and `busy_o`=1.
    - Go to BUSY.
- BUSY:
  - `mem_enable_o`, `mem_write_o`, `mem_addr_o` and `mem_data_o` are held constant.
  - Requester enables are ignored.
  - On `mem_ack_i`=1:
    - Capture `mem_data_i` into `rdata_o`.
    - Clear `mem_enable_o` and `mem_write_o`.
    - Assert the owner's ack (`i_ack_o` or `d_ack_o`).
    - Go to DONE.
- DONE:
  - Lasts exactly one cycle; the owner's ack is high for this cycle only.
  - No arbitration happens, so a requester whose enable is still high in this cycle is not re-issued.
  - Go to IDLE and clear `busy_o`.
- `rdata_o` holds its value until the next capture. It is also captured on writes, and its content is meaningless for writes.
- `mem_ack_i` outside BUSY is ignored.
- `mem_addr_o` and `mem_data_o` keep their last values when idle.
- Reset values, applied immediately on `rst_i`: state=IDLE, all acks=0, `mem_enable_o`=0, `mem_write_o`=0, `busy_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `rdata_o`=0, `last_grant`=D (so I wins the first round-robin tie).
- Reset during BUSY abandons the transaction with no ack. The requester must re-issue its request after reset.

## Timing
- Let the enable be sampled high in IDLE at edge k.
  - `mem_enable_o` is high from cycle k+1.
  - If `mem_ack_i` is high in cycle m (m ≥ k+1), the owner's ack and `rdata_o` are valid in cycle m+1.
  - `mem_enable_o` is low from m+1.
  - The arbiter is in IDLE at m+2, and a new grant can issue at that edge.
- Minimum spacing between grants: 3 cycles.
- The loser of a tie keeps its enable high and is granted at the first IDLE cycle after the winner's DONE. Under round-robin, starvation is therefore bounded to one transaction.
- The owner's ack is never asserted in the same cycle as `mem_ack_i`.
- At most one of `i_ack_o` and `d_ack_o` is high in any cycle.

## Test plan
- Single I read:
  - Stimulus: `i_enable_i`=1, `i_addr_i`=0x0000_0124; memory acks 10 cycles after `mem_enable_o` rises with `mem_data_i`=0xAA…A.
  - Required: `mem_addr_o`=0x0000_0120, `mem_write_o`=0; `i_ack_o` is a single pulse one cycle after `mem_ack_i`; `rdata_o`=0xAA…A; `d_ack_o` stays 0.
- D write:
  - Stimulus: `d_write_i`=1, `d_addr_i`=0x40, `d_data_i`=0x1234…; memory acks.
  - Required: `mem_write_o`=1 and `mem_data_o`=0x1234… held unchanged for the whole BUSY period; `d_ack_o` pulses once; `mem_enable_o` falls the cycle after `mem_ack_i`.
- Simultaneous requests, `DATA_PRIO`=0, after reset:
  - Stimulus: both enables asserted together.
  - Required: I is granted first; D is granted at the edge following the DONE cycle; the next simultaneous pair grants in the order D then I.
- Simultaneous requests, `DATA_PRIO`=1, repeated 3 times:
  - Required: D is granted first every time; I is served between the D transactions.
- Sticky enable:
  - Stimulus: I keeps `i_enable_i` high through DONE with an unchanged address.
  - Required: exactly one ack per grant; the second grant starts no earlier than 3 cycles after the first.
- Reset mid-BUSY:
  - Stimulus: assert `rst_i` while waiting for `mem_ack_i`.
  - Required: `mem_enable_o`=0, `busy_o`=0 and all acks=0 immediately, without waiting for a clock edge; a late `mem_ack_i` after reset produces no ack.
